// File: rtl/preg_free_list_pkg.sv
// Shared physical-register constants and types for rename, register file and ROB.
// Tags below NUM_AREG hold the architectural mapping at reset.
package preg_free_list_pkg;

  localparam int PREG_WIDTH    = 6;
  localparam int NUM_PREG      = 64;
  localparam int NUM_AREG      = 32;
  localparam int FL_CNT_WIDTH  = PREG_WIDTH + 1;
  localparam int FREE_BASE_RST = NUM_AREG;
  localparam int NUM_FREE_RST  = NUM_PREG - NUM_AREG;
  // Tag 0 can never be free, so one slot of the pool is always unused.
  localparam int MAX_OCCUPANCY = NUM_PREG - 1;

  typedef logic [PREG_WIDTH-1:0]   preg_tag_t;
  typedef logic [FL_CNT_WIDTH-1:0] fl_cnt_t;
  typedef logic [FL_CNT_WIDTH:0]   fl_occ_t;

  function automatic logic [1:0] pop2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags: one allocation and up to two
// reclaims per cycle. Define FREELIST_CHECK_EN to trap double frees (adds dup_err_tag).
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_grant,
  output logic [PREG_WIDTH-1:0] alloc_tag,
  input  logic                  free0_valid,
  input  logic [PREG_WIDTH-1:0] free0_tag,
  input  logic                  free1_valid,
  input  logic [PREG_WIDTH-1:0] free1_tag,
  output logic [FL_CNT_WIDTH-1:0] free_count,
`ifdef FREELIST_CHECK_EN
  output logic [PREG_WIDTH-1:0] dup_err_tag,
`endif
  output logic                  empty,
  output logic                  overflow_err
);

  preg_tag_t mem [NUM_PREG];
  preg_tag_t head;
  preg_tag_t tail;
  preg_tag_t tail_p1;
  fl_cnt_t   count;
  logic      err_q;

  logic      eff0, eff1;
  logic      acc0, acc1;
  logic      dup0, dup1;
  logic      ovf;
  logic      push0, push1;
  logic [1:0] nfree;
  fl_occ_t   occ_next;

`ifdef FREELIST_CHECK_EN
  logic [NUM_PREG-1:0] in_list;
  preg_tag_t           dup_tag_q;
`endif

  assign empty        = (count == '0);
  assign free_count   = count;
  assign alloc_tag    = mem[head];
  assign alloc_grant  = alloc_req && !empty && !rst;
  assign overflow_err = err_q;
  assign tail_p1      = tail + preg_tag_t'(1);

  // A release of tag 0 is the x0 mapping retiring and never enters the pool.
  assign eff0 = free0_valid && (free0_tag != '0);
  assign eff1 = free1_valid && (free1_tag != '0);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    dup0 = 1'b0;
    dup1 = 1'b0;
`ifdef FREELIST_CHECK_EN
    dup0 = eff0 && in_list[free0_tag];
    dup1 = eff1 && (in_list[free1_tag] || (eff0 && (free0_tag == free1_tag)));
`endif
    acc0 = eff0 && !dup0;
    acc1 = eff1 && !dup1;
  end

  // Occupancy check covers frees and the grant together, so a full list may
  // still accept a free in a cycle that also hands a tag out.
  always_comb begin
    nfree    = pop2(acc0, acc1);
    occ_next = {1'b0, count} + fl_occ_t'(nfree) - fl_occ_t'(alloc_grant);
    ovf      = (occ_next > fl_occ_t'(MAX_OCCUPANCY));
    push0    = acc0 && !ovf;
    push1    = acc1 && !ovf;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= preg_tag_t'(NUM_FREE_RST);
      count <= fl_cnt_t'(NUM_FREE_RST);
      err_q <= 1'b0;
    end else begin
      if (alloc_grant) head <= head + preg_tag_t'(1);
      tail  <= tail + preg_tag_t'(pop2(push0, push1));
      count <= count + fl_cnt_t'(pop2(push0, push1)) - fl_cnt_t'(alloc_grant);
      if (ovf || dup0 || dup1) err_q <= 1'b1;
    end
  end

  // NOTE: the storage array is reset on purpose: the initial free tags must be
  // present in order, so this memory cannot be left to power-up contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        mem[i] <= (i < NUM_FREE_RST) ? preg_tag_t'(i + FREE_BASE_RST) : '0;
      end
    end else begin
      if (push0) mem[tail] <= free0_tag;
      if (push1) mem[push0 ? tail_p1 : tail] <= free1_tag;
    end
  end

`ifdef FREELIST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        in_list[i] <= (i >= FREE_BASE_RST);
      end
      dup_tag_q <= '0;
    end else begin
      if (alloc_grant) in_list[alloc_tag] <= 1'b0;
      if (push0)       in_list[free0_tag] <= 1'b1;
      if (push1)       in_list[free1_tag] <= 1'b1;
      if (dup1)        dup_tag_q <= free1_tag;
      else if (dup0)   dup_tag_q <= free0_tag;
    end
  end

  assign dup_err_tag = dup_tag_q;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: reset pool, dual free, tag-0 filter,
// simultaneous alloc/free, wrap-around ordering, overflow and duplicate frees.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_grant;
  preg_tag_t  alloc_tag;
  logic       free0_valid;
  preg_tag_t  free0_tag;
  logic       free1_valid;
  preg_tag_t  free1_tag;
  fl_cnt_t    free_count;
  logic       empty;
  logic       overflow_err;
`ifdef FREELIST_CHECK_EN
  preg_tag_t  dup_err_tag;
`endif

  int checks = 0;
  int errors = 0;

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_tag    (alloc_tag),
    .free0_valid  (free0_valid),
    .free0_tag    (free0_tag),
    .free1_valid  (free1_valid),
    .free1_tag    (free1_tag),
    .free_count   (free_count),
`ifdef FREELIST_CHECK_EN
    .dup_err_tag  (dup_err_tag),
`endif
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled 1 unit later.
  task automatic drive(input logic req, input logic v0, input preg_tag_t t0,
                       input logic v1, input preg_tag_t t1);
    alloc_req   = req;
    free0_valid = v0;
    free0_tag   = t0;
    free1_valid = v1;
    free1_tag   = t1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  preg_tag_t model_q[$];
  preg_tag_t out_q[$];

  initial begin
    logic      req, v0, v1, exp_grant;
    preg_tag_t t0, t1;
    int        idx, guard;

    // Reset wins over concurrent requests.
    rst = 1'b1;
    drive(1'b1, 1'b1, 6'd3, 1'b1, 6'd4);
    tick();
    tick();
    rst = 1'b0;
    idle();
    check("rst_count", free_count, 32);
    check("rst_empty", empty, 0);
    check("rst_tag", alloc_tag, 32);
    check("rst_err", overflow_err, 0);
    check("rst_grant", alloc_grant, 0);

    // Drain the reset pool in order.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      check("drain_grant", alloc_grant, 1);
      check("drain_tag", alloc_tag, 32 + i);
      tick();
    end
    check("drained_empty", empty, 1);
    check("drained_grant", alloc_grant, 0);
    check("drained_count", free_count, 0);

    // Dual free at empty: no bypass, tags appear next cycle in lane order.
    drive(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    check("dual_nobypass", alloc_grant, 0);
    tick();
    idle();
    check("dual_count", free_count, 2);
    check("dual_tag", alloc_tag, 5);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("dual_alloc0", alloc_tag, 5);
    tick();
    check("dual_alloc1_grant", alloc_grant, 1);
    check("dual_alloc1", alloc_tag, 9);
    tick();
    idle();
    check("dual_drained", free_count, 0);

    // Tag 0 is filtered on either lane; then lane 1 alone lands at the tail.
    drive(1'b0, 1'b1, 6'd0, 1'b0, '0);
    tick();
    check("tag0_lane0", free_count, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 6'd0);
    tick();
    check("tag0_lane1", free_count, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 6'd7);
    tick();
    idle();
    check("lane1_count", free_count, 1);
    check("lane1_tag", alloc_tag, 7);

    // Simultaneous alloc and free at count 1.
    drive(1'b1, 1'b1, 6'd12, 1'b0, '0);
    check("simul1_grant", alloc_grant, 1);
    check("simul1_tag", alloc_tag, 7);
    tick();
    idle();
    check("simul1_count", free_count, 1);
    check("simul1_next", alloc_tag, 12);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    idle();
    check("simul1_empty", empty, 1);
    // Same stimulus at empty: no grant, freed tag available next cycle.
    drive(1'b1, 1'b1, 6'd12, 1'b0, '0);
    check("simul0_grant", alloc_grant, 0);
    tick();
    idle();
    check("simul0_count", free_count, 1);
    check("simul0_tag", alloc_tag, 12);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    idle();

    // Random alloc/free traffic against a FIFO model; pointers wrap past 63.
    out_q = {6'd5, 6'd9, 6'd7, 6'd12};
    for (int t = 32; t < 64; t++) out_q.push_back(preg_tag_t'(t));
    for (int c = 0; c < 200; c++) begin
      req = ($urandom_range(0, 3) != 0);
      v0 = 1'b0; t0 = '0; v1 = 1'b0; t1 = '0;
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out_q.size() - 1);
        v0 = 1'b1; t0 = out_q[idx]; out_q.delete(idx);
      end
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out_q.size() - 1);
        v1 = 1'b1; t1 = out_q[idx]; out_q.delete(idx);
      end
      exp_grant = req && (model_q.size() > 0);
      // Unpicked lanes sometimes carry a valid tag-0 release, which must be ignored.
      drive(req, v0 | ($urandom_range(0, 3) == 0), t0, v1 | ($urandom_range(0, 3) == 0), t1);
      check("rnd_count", free_count, model_q.size());
      check("rnd_grant", alloc_grant, exp_grant);
      if (exp_grant) check("rnd_tag", alloc_tag, model_q[0]);
      tick();
      if (exp_grant) out_q.push_back(model_q.pop_front());
      if (v0) model_q.push_back(t0);
      if (v1) model_q.push_back(t1);
    end
    guard = 0;
    while (model_q.size() > 0 && guard < 64) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      check("rnd_drain_tag", alloc_tag, model_q.pop_front());
      tick();
      guard++;
    end
    idle();
    check("rnd_drained", empty, 1);
    check("rnd_no_err", overflow_err, 0);

    // Mid-operation reset, then fill to 63 and overflow.
    rst = 1'b1;
    drive(1'b1, 1'b1, 6'd3, 1'b1, 6'd4);
    tick();
    rst = 1'b0;
    idle();
    check("rst2_count", free_count, 32);
    check("rst2_tag", alloc_tag, 32);
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, 1'b1, preg_tag_t'(2 * k + 1), 1'b1, preg_tag_t'(2 * k + 2));
      tick();
    end
    check("fill_62", free_count, 62);
    drive(1'b0, 1'b1, 6'd31, 1'b0, '0);
    tick();
    check("fill_63", free_count, 63);
    check("fill_no_err", overflow_err, 0);
    drive(1'b0, 1'b1, 6'd31, 1'b0, '0);
    tick();
    idle();
    check("ovf_err", overflow_err, 1);
    check("ovf_count", free_count, 63);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("ovf_grant_tag", alloc_tag, 32);
    tick();
    idle();
    check("ovf_sticky", overflow_err, 1);
    check("ovf_after_alloc", free_count, 62);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared", overflow_err, 0);

`ifdef FREELIST_CHECK_EN
    // Double free of the same tag across cycles.
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("dup_alloc", alloc_tag, 32);
    tick();
    drive(1'b0, 1'b1, 6'd32, 1'b0, '0);
    tick();
    check("dup_first_ok", free_count, 32);
    check("dup_first_err", overflow_err, 0);
    drive(1'b0, 1'b1, 6'd32, 1'b0, '0);
    tick();
    idle();
    check("dup_count", free_count, 32);
    check("dup_err", overflow_err, 1);
    check("dup_tag", dup_err_tag, 32);
    // Same tag on both lanes: lane 1 dropped, lane 0 proceeds.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    tick();
    drive(1'b0, 1'b1, 6'd33, 1'b1, 6'd33);
    tick();
    idle();
    check("dup2_count", free_count, 31);
    check("dup2_err", overflow_err, 1);
    check("dup2_tag", dup_err_tag, 33);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
